// File: rtl/contador_pkg.sv
// ============================================================================
// contador_pkg : shared direction constants and width helper for counters
// Rev 1.0
// ============================================================================
`default_nettype none

package contador_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Ceiling log2, never below 1 so a single-state counter still gets a bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_tick.sv
// ============================================================================
// divisor_tick : enable-gated phase counter, tick on the last phase
// Rev 1.0
// ============================================================================
`default_nettype none

module divisor_tick
   import contador_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("divisor_tick: PRESCALE must be >= 1");
   end

   localparam int                 PHASE_W = clog2(PRESCALE);
   localparam logic [PHASE_W-1:0] LAST    = PHASE_W'(PRESCALE - 1);

   logic [PHASE_W-1:0] r_phase;

   // With PRESCALE=1 LAST is 0, so the phase never leaves 0 and tick stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= '0;
      end else if (sync_clr) begin
         r_phase <= '0;
      end else if (en) begin
         r_phase <= (r_phase == LAST) ? '0 : r_phase + 1'b1;
      end
   end

   assign tick = (r_phase == LAST);

endmodule

`default_nettype wire

// File: rtl/contador_parametrico.sv
// ============================================================================
// contador_parametrico : up/down modulo-N counter, prescaler, wrap/saturate
// Rev 1.0
// ============================================================================
`default_nettype none

module contador_parametrico
   import contador_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULO   = 16,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             tc,
   output logic             wrap
);

   if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
      $error("contador_parametrico: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
   localparam logic             WRAPS   = (SATURATE == 0);

   logic             w_tick;
   logic             w_at_limit;
   logic             w_wrap_event;
   logic [WIDTH-1:0] w_load_clamped;

   divisor_tick #(
      .PRESCALE (PRESCALE)
   ) u_divisor_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync_clr (clr | load),
      .tick     (w_tick)
   );

   assign w_at_limit = (dir == DIR_UP) ? (count == MAX_VAL) : (count == '0);
   assign step       = w_tick & en;
   assign tc         = step & w_at_limit;

   // Compared one bit wider so MODULO == 2**WIDTH never clamps.
   assign w_load_clamped = ({1'b0, load_val} >= (WIDTH + 1)'(MODULO)) ? MAX_VAL : load_val;

   // clr/load outrank the step, so a coincident terminal step must not pulse wrap.
   assign w_wrap_event = tc & WRAPS & ~clr & ~load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= w_load_clamped;
      end else if (step) begin
         if (dir == DIR_UP) begin
            if (count != MAX_VAL) begin
               count <= count + 1'b1;
            end else if (WRAPS) begin
               count <= '0;
            end
         end else begin
            if (count != '0) begin
               count <= count - 1'b1;
            end else if (WRAPS) begin
               count <= MAX_VAL;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap <= 1'b0;
      end else begin
         wrap <= w_wrap_event;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_contador_parametrico.sv
// ============================================================================
// tb_contador_parametrico : directed checks on wrap, saturate and prescaled variants
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_contador_parametrico;
   import contador_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       dir = DIR_UP;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] count_a, count_s, count_p;
   logic       step_a, step_s, step_p;
   logic       tc_a, tc_s, tc_p;
   logic       wrap_a, wrap_s, wrap_p;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   contador_parametrico #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .count(count_a), .step(step_a), .tc(tc_a), .wrap(wrap_a));

   contador_parametrico #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .count(count_s), .step(step_s), .tc(tc_s), .wrap(wrap_s));

   contador_parametrico #(.WIDTH(4), .MODULO(10), .PRESCALE(4), .SATURATE(0)) dut_p (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .count(count_p), .step(step_p), .tc(tc_p), .wrap(wrap_p));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (count_a !== 4'd0 || wrap_a !== 1'b0 || tc_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: count=%0d wrap=%b tc=%b expected 0/0/0", count_a, wrap_a, tc_a);
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (count_a !== 4'd0 || count_p !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: count_a=%0d count_p=%0d expected 0", count_a, count_p);
      end
   endtask

   task automatic test_count_up();
      int exp;
      en  = 1'b1;
      dir = DIR_UP;
      #1;
      for (int i = 0; i < 12; i++) begin
         exp = i % 10;
         checks++;
         if (count_a !== 4'(exp) || tc_a !== (exp == 9) || wrap_a !== (i == 10)) begin
            errors++;
            $display("FAIL up_count[%0d]: count=%0d tc=%b wrap=%b expected %0d/%b/%b",
                     i, count_a, tc_a, wrap_a, exp, (exp == 9), (i == 10));
         end
         tick();
      end
   endtask

   task automatic test_count_down();
      int exp;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (count_a !== 4'd0 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL clr_no_wrap: count=%0d wrap=%b expected 0/0", count_a, wrap_a);
      end
      dir = DIR_DOWN;
      #1;
      for (int i = 0; i < 12; i++) begin
         exp = (10 - (i % 10)) % 10;
         checks++;
         if (count_a !== 4'(exp) || tc_a !== (exp == 0) || wrap_a !== (i == 1 || i == 11)) begin
            errors++;
            $display("FAIL down_count[%0d]: count=%0d tc=%b wrap=%b expected %0d/%b/%b",
                     i, count_a, tc_a, wrap_a, exp, (exp == 0), (i == 1 || i == 11));
         end
         tick();
      end
   endtask

   task automatic test_saturate();
      int cur;
      dir      = DIR_UP;
      load     = 1'b1;
      load_val = 4'd7;
      tick();
      load = 1'b0;
      cur  = 7;
      checks++;
      if (count_s !== 4'd7) begin
         errors++;
         $display("FAIL sat_load: count=%0d expected 7", count_s);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (tc_s !== (cur == 9)) begin
            errors++;
            $display("FAIL sat_tc[%0d]: tc=%b expected %b", k, tc_s, (cur == 9));
         end
         tick();
         cur = (cur < 9) ? cur + 1 : 9;
         checks++;
         if (count_s !== 4'(cur) || wrap_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_count[%0d]: count=%0d wrap=%b expected %0d/0", k, count_s, wrap_s, cur);
         end
      end
   endtask

   task automatic test_prescale();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (step_p !== ((k % 4) == 3)) begin
            errors++;
            $display("FAIL pre_step[%0d]: step=%b expected %b", k, step_p, ((k % 4) == 3));
         end
         tick();
         checks++;
         if (count_p !== 4'((k + 1) / 4)) begin
            errors++;
            $display("FAIL pre_count[%0d]: count=%0d expected %0d", k, count_p, (k + 1) / 4);
         end
      end
      // Phase now 0, count 2: two edges, two frozen cycles, two more edges.
      for (int k = 0; k < 6; k++) begin
         en = !(k == 2 || k == 3);
         #1;
         if (k == 2) begin
            checks++;
            if (step_p !== 1'b0) begin
               errors++;
               $display("FAIL pre_frozen_step: step=%b expected 0", step_p);
            end
         end
         tick();
         checks++;
         if (count_p !== ((k == 5) ? 4'd3 : 4'd2)) begin
            errors++;
            $display("FAIL pre_stretch[%0d]: count=%0d expected %0d", k, count_p, (k == 5) ? 3 : 2);
         end
      end
   endtask

   task automatic test_load_clr();
      en       = 1'b1;
      load     = 1'b1;
      load_val = 4'd12;
      tick();
      checks++;
      if (count_a !== 4'd9 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: count=%0d wrap=%b expected 9/0", count_a, wrap_a);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (count_a !== 4'd0 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL clr_over_load: count=%0d wrap=%b expected 0/0", count_a, wrap_a);
      end
      en       = 1'b0;
      load_val = 4'd5;
      tick();
      load = 1'b0;
      checks++;
      if (count_a !== 4'd5) begin
         errors++;
         $display("FAIL load_no_en: count=%0d expected 5", count_a);
      end
   endtask

   task automatic test_async_reset();
      en  = 1'b1;
      dir = DIR_UP;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (5) tick();
      checks++;
      if (count_a !== 4'd5) begin
         errors++;
         $display("FAIL pre_reset_count: count=%0d expected 5", count_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (count_a !== 4'd0 || wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_mid: count=%0d wrap=%b expected 0/0", count_a, wrap_a);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (count_a !== 4'd1) begin
         errors++;
         $display("FAIL resume_after_reset: count=%0d expected 1", count_a);
      end
      // Reset must also kill a wrap pulse that is currently high.
      load     = 1'b1;
      load_val = 4'd9;
      tick();
      load = 1'b0;
      tick();
      checks++;
      if (count_a !== 4'd0 || wrap_a !== 1'b1) begin
         errors++;
         $display("FAIL wrap_before_reset: count=%0d wrap=%b expected 0/1", count_a, wrap_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (wrap_a !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_wrap: wrap=%b expected 0", wrap_a);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_prescale();
      test_load_clr();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
